// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack bus handshake, byte lanes,
// load extension, pipeline stall, misalignment and bus-timeout reporting.
module mem_access_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_M,
   input  logic        MemWrite_M,
   input  logic [2:0]  MemOp_M,
   input  logic [31:0] ALUresult_M,
   input  logic [31:0] Read2_M,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   output logic [31:0] MemData_M,
   output logic        mem_stall,
   output logic        addr_exc,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rdata_q;

   logic        access;
   logic        is_half;
   logic        is_byte;
   logic        is_signed;
   logic        start;
   logic        timeout_hit;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] lane;
   logic [31:0] load_ext;

   // Access-size decode; unlisted encodings behave as word accesses
   always_comb begin
      is_half   = 1'b0;
      is_byte   = 1'b0;
      is_signed = 1'b1;
      case (MemOp_M)
         3'b001: is_half = 1'b1;
         3'b010: begin
            is_half   = 1'b1;
            is_signed = 1'b0;
         end
         3'b011: is_byte = 1'b1;
         3'b100: begin
            is_byte   = 1'b1;
            is_signed = 1'b0;
         end
         default: begin
            is_half   = 1'b0;
            is_byte   = 1'b0;
            is_signed = 1'b1;
         end
      endcase
   end

   assign access   = MemRead_M | MemWrite_M;
   assign addr_exc = access & ((!is_half && !is_byte && (ALUresult_M[1:0] != 2'b00)) ||
                               (is_half && ALUresult_M[0]));
   assign start    = access & !addr_exc;

   // Byte enables and replicated store lanes for the current EX/MEM contents
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = Read2_M;
      if (is_half) begin
         be_calc    = 4'b0011 << ALUresult_M[1:0];
         wdata_calc = {2{Read2_M[15:0]}};
      end else if (is_byte) begin
         be_calc    = 4'b0001 << ALUresult_M[1:0];
         wdata_calc = {4{Read2_M[7:0]}};
      end else begin
         be_calc    = 4'b1111;
         wdata_calc = Read2_M;
      end
   end

   // Load lane extraction and sign/zero extension from the latched read word
   always_comb begin
      lane     = rdata_q >> {ALUresult_M[1:0], 3'b000};
      load_ext = lane;
      if (is_half) begin
         load_ext = {{16{is_signed & lane[15]}}, lane[15:0]};
      end else if (is_byte) begin
         load_ext = {{24{is_signed & lane[7]}}, lane[7:0]};
      end else begin
         load_ext = lane;
      end
   end

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   assign mem_addr    = {ALUresult_M[31:2], 2'b00};
   assign mem_wdata   = wdata_calc;
   assign MemData_M   = (state == DONE) ? load_ext : 32'h0000_0000;
   assign bus_err     = (state == REQ) & timeout_hit & !mem_ack;
   // IDLE term is gated by reset so the stall drops at once when reset asserts
   assign mem_stall   = (state == REQ) | (reset & (state == IDLE) & start);

   // Access FSM with registered bus request, write strobe and byte enables
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= {CNT_W{1'b0}};
         rdata_q <= 32'h0000_0000;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         mem_be  <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               cnt <= {CNT_W{1'b0}};
               if (start) begin
                  state   <= REQ;
                  mem_req <= 1'b1;
                  mem_we  <= MemWrite_M;
                  mem_be  <= be_calc;
               end
            end
            REQ: begin
               if (mem_ack || timeout_hit) begin
                  rdata_q <= mem_ack ? mem_rdata : 32'h0000_0000;
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= 4'b0000;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               mem_be  <= 4'b0000;
            end
         endcase
      end
   end

endmodule
